// File: rtl/mole_actuator_pkg.sv
// Shared types and default timing for the mole coil actuator.
// The default timing assumes a 100 MHz clock.
package mole_actuator_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PEND = 3'd1,
    S_KICK = 3'd2,
    S_HOLD = 3'd3,
    S_COOL = 3'd4
  } coil_state_e;

  localparam int unsigned DEF_N_MOLE     = 3;
  localparam int unsigned DEF_KICK_CYC   = 2_000_000;
  localparam int unsigned DEF_PWM_PERIOD = 1000;
  localparam int unsigned DEF_PWM_DUTY   = 400;
  localparam int unsigned DEF_COOL_CYC   = 10_000_000;
  localparam int unsigned DEF_HOLD_W     = 28;

  // The kick and cool phases share one down-counter, so it must be wide enough for the longer phase.
  function automatic int unsigned timer_width(int unsigned kick_cyc, int unsigned cool_cyc);
    return $clog2(((kick_cyc > cool_cyc) ? kick_cyc : cool_cyc) + 1);
  endfunction

endpackage

// File: rtl/mole_actuator_if.sv
// Command and drive bundle between the game logic (master) and the coil actuator (slave).
interface mole_actuator_if #(
  parameter int unsigned N_MOLE = 3,
  parameter int unsigned HOLD_W = 28
);
  logic [N_MOLE-1:0] raise;
  logic [N_MOLE-1:0] drop;
  logic [HOLD_W-1:0] hold_cycles;
  logic [N_MOLE-1:0] mole_en;
  logic [N_MOLE-1:0] up;
  logic [N_MOLE-1:0] busy;
  logic [N_MOLE-1:0] timeout;

  modport master (output raise, drop, hold_cycles, input mole_en, up, busy, timeout);
  modport slave  (input raise, drop, hold_cycles, output mole_en, up, busy, timeout);
endinterface

// File: rtl/mole_actuator_coil_ch.sv
// One coil channel: request, kick, PWM hold and cooldown phases.
// Kick/cool share one timer; the hold time has a separate counter.
module mole_actuator_coil_ch
  import mole_actuator_pkg::*;
#(
  parameter int unsigned KICK_CYC = DEF_KICK_CYC,
  parameter int unsigned COOL_CYC = DEF_COOL_CYC,
  parameter int unsigned HOLD_W   = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raise_i,
  input  logic              drop_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic              grant_i,
  input  logic              pwm_on_i,
  output logic              pend_o,
  output logic              in_kick_o,
  output logic              mole_en_o,
  output logic              up_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned       TW        = timer_width(KICK_CYC, COOL_CYC);
  localparam logic [TW-1:0]     KICK_LOAD = TW'(KICK_CYC - 1);
  localparam logic [TW-1:0]     COOL_LOAD = TW'(COOL_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  coil_state_e       state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              mole_en_q, mole_en_d;
  logic              up_q, up_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic              enter_cool;

  always_comb begin
    // NOTE: every _d is given its default first so no branch of the case can infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    enter_cool = 1'b0;
    case (state_q)
      S_IDLE: if (raise_i && !drop_i) state_d = S_PEND;
      S_PEND: begin
        if (drop_i) begin
          state_d = S_IDLE;
        end else if (grant_i) begin
          state_d = S_KICK;
          timer_d = KICK_LOAD;
          hold_d  = hold_cycles_i;
        end
      end
      S_KICK: begin
        if (drop_i)               enter_cool = 1'b1;
        else if (timer_q != '0)   timer_d    = timer_q - 1'b1;
        else if (hold_q == '0)    enter_cool = 1'b1;
        else                      state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (drop_i) begin
          enter_cool = 1'b1;
        end else if (hold_q == HOLD_ONE) begin
          enter_cool = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      S_COOL: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_cool) begin
      state_d = S_COOL;
      timer_d = COOL_LOAD;
      hold_d  = '0;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    mole_en_d = (state_d == S_KICK) || ((state_d == S_HOLD) && pwm_on_i);
    up_d      = (state_d == S_KICK) || (state_d == S_HOLD);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      hold_q    <= '0;
      mole_en_q <= 1'b0;
      up_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      mole_en_q <= mole_en_d;
      up_q      <= up_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // A channel on its last kick cycle (or being dropped) frees the kick slot for this edge.
  assign pend_o    = (state_q == S_PEND);
  assign in_kick_o = (state_q == S_KICK) && (timer_q != '0) && !drop_i;
  assign mole_en_o = mole_en_q;
  assign up_o      = up_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/mole_actuator.sv
// Multi-channel coil actuator: shared hold-phase PWM counter plus a fixed-priority arbiter
// that lets only one coil kick at a time to limit supply inrush.
module mole_actuator
  import mole_actuator_pkg::*;
#(
  parameter int unsigned N_MOLE     = DEF_N_MOLE,
  parameter int unsigned KICK_CYC   = DEF_KICK_CYC,
  parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int unsigned PWM_DUTY   = DEF_PWM_DUTY,
  parameter int unsigned COOL_CYC   = DEF_COOL_CYC,
  parameter int unsigned HOLD_W     = DEF_HOLD_W
) (
  input  logic            clk,
  input  logic            rst,
  mole_actuator_if.slave  bus
);

  localparam int unsigned    PW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned    PWC      = PW + 1;
  localparam logic [PW-1:0]  PWM_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [PWC-1:0] DUTY_CMP = PWC'(PWM_DUTY);

  logic [PW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic              pwm_on;
  logic [N_MOLE-1:0] pend, in_kick, grant;
  logic [N_MOLE-1:0] mole_en_w, up_w, busy_w, timeout_w;

  // pwm_on describes the count of the coming cycle, matching the registered coil outputs.
  assign pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
  assign pwm_on    = ({1'b0, pwm_cnt_d} < DUTY_CMP);

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  always_comb begin
    grant = '0;
    if (in_kick == '0) begin
      for (int i = 0; i < N_MOLE; i++) begin
        if (pend[i] && (grant == '0)) grant[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_MOLE; g++) begin : g_ch
    mole_actuator_coil_ch #(
      .KICK_CYC (KICK_CYC),
      .COOL_CYC (COOL_CYC),
      .HOLD_W   (HOLD_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .raise_i       (bus.raise[g]),
      .drop_i        (bus.drop[g]),
      .hold_cycles_i (bus.hold_cycles),
      .grant_i       (grant[g]),
      .pwm_on_i      (pwm_on),
      .pend_o        (pend[g]),
      .in_kick_o     (in_kick[g]),
      .mole_en_o     (mole_en_w[g]),
      .up_o          (up_w[g]),
      .busy_o        (busy_w[g]),
      .timeout_o     (timeout_w[g])
    );
  end

  assign bus.mole_en = mole_en_w;
  assign bus.up      = up_w;
  assign bus.busy    = busy_w;
  assign bus.timeout = timeout_w;

endmodule

// File: tb/tb_mole_actuator.sv
// Bench for mole_actuator: a phase/age model checked every cycle, plus
// hand-computed waveform expectations for each directed scenario.
module tb_mole_actuator;

  localparam int N     = 3;
  localparam int KICK  = 4;
  localparam int P     = 4;
  localparam int DUTY  = 1;
  localparam int COOL  = 3;
  localparam int HW    = 8;
  localparam int WMAX  = 64;

  localparam int M_IDLE = 0, M_PEND = 1, M_KICK = 2, M_HOLD = 3, M_COOL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mole_actuator_if #(.N_MOLE(N), .HOLD_W(HW)) bus ();

  mole_actuator #(
    .N_MOLE(N), .KICK_CYC(KICK), .PWM_PERIOD(P), .PWM_DUTY(DUTY), .COOL_CYC(COOL), .HOLD_W(HW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase[N];
  int m_age[N];
  int m_hold[N];
  int m_pwm;
  logic [N-1:0] m_en, m_up, m_busy, m_to;

  always @(posedge clk) begin : model
    int  winner;
    int  nxt;
    bit  slot_taken;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_phase[i] = M_IDLE; m_age[i] = 0; m_hold[i] = 0;
      end
      m_pwm = 0;
      m_to  = '0;
    end else begin
      slot_taken = 1'b0;
      for (int i = 0; i < N; i++)
        if (m_phase[i] == M_KICK && m_age[i] + 1 < KICK && !bus.drop[i]) slot_taken = 1'b1;
      winner = -1;
      if (!slot_taken)
        for (int i = 0; i < N; i++)
          if (winner < 0 && m_phase[i] == M_PEND) winner = i;
      m_pwm = (m_pwm + 1) % P;
      for (int i = 0; i < N; i++) begin
        nxt     = m_phase[i];
        m_to[i] = 1'b0;
        case (m_phase[i])
          M_IDLE: if (bus.raise[i] && !bus.drop[i]) nxt = M_PEND;
          M_PEND: begin
            if (bus.drop[i]) nxt = M_IDLE;
            else if (winner == i) begin nxt = M_KICK; m_hold[i] = int'(bus.hold_cycles); end
          end
          M_KICK: begin
            if (bus.drop[i]) nxt = M_COOL;
            else if (m_age[i] + 1 == KICK) nxt = (m_hold[i] == 0) ? M_COOL : M_HOLD;
          end
          M_HOLD: begin
            if (bus.drop[i]) nxt = M_COOL;
            else if (m_age[i] + 1 == m_hold[i]) begin nxt = M_COOL; m_to[i] = 1'b1; end
          end
          default: if (m_age[i] + 1 == COOL) nxt = M_IDLE;
        endcase
        m_age[i]   = (nxt == m_phase[i]) ? m_age[i] + 1 : 0;
        m_phase[i] = nxt;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_en[i]   = (m_phase[i] == M_KICK) || (m_phase[i] == M_HOLD && m_pwm < DUTY);
      m_up[i]   = (m_phase[i] == M_KICK) || (m_phase[i] == M_HOLD);
      m_busy[i] = (m_phase[i] != M_IDLE);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_mole_en", 32'(bus.mole_en), 32'(m_en));
      check("model_up",      32'(bus.up),      32'(m_up));
      check("model_busy",    32'(bus.busy),    32'(m_busy));
      check("model_timeout", 32'(bus.timeout), 32'(m_to));
    end
  end

  // ---------------- directed stimulus windows ----------------
  logic [N-1:0] st_raise[WMAX], st_drop[WMAX];
  logic         st_rst[WMAX];
  logic [N-1:0] r_en[WMAX], r_up[WMAX], r_busy[WMAX], r_to[WMAX];

  task automatic clear_stim();
    for (int n = 0; n < WMAX; n++) begin
      st_raise[n] = '0; st_drop[n] = '0; st_rst[n] = 1'b0;
    end
  endtask

  // Iteration n records the outputs of cycle n, then drives the inputs sampled at the next edge.
  task automatic run_window(input int len, input logic [HW-1:0] hold);
    bus.hold_cycles = hold;
    for (int n = 0; n < len; n++) begin
      @(negedge clk);
      r_en[n] = bus.mole_en; r_up[n] = bus.up; r_busy[n] = bus.busy; r_to[n] = bus.timeout;
      bus.raise = st_raise[n];
      bus.drop  = st_drop[n];
      rst       = st_rst[n];
    end
    bus.raise = '0; bus.drop = '0; rst = 1'b0;
  endtask

  function automatic int cnt(input int sel, input int ch, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) begin
      case (sel)
        0: c += int'(r_en[n][ch]);
        1: c += int'(r_to[n][ch]);
        default: c += int'(r_busy[n][ch]);
      endcase
    end
    return c;
  endfunction

  function automatic int first_en(input int ch, input int len);
    for (int n = 0; n < len; n++) if (r_en[n][ch]) return n;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.raise = '0; bus.drop = '0; bus.hold_cycles = '0;
    rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset_mole_en", 32'(bus.mole_en), 32'd0);
    check("reset_busy",    32'(bus.busy),    32'd0);
    check("reset_up",      32'(bus.up),      32'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single raise, hold 8
    clear_stim(); st_raise[0] = 3'b001;
    run_window(20, 8'd8);
    check("t1_pend_no_drive", 32'(r_en[1][0]), 32'd0);
    check("t1_pend_busy",     32'(r_busy[1][0]), 32'd1);
    check("t1_kick_cycles",   32'(cnt(0, 0, 2, 5)), 32'd4);
    check("t1_hold_pwm",      32'(cnt(0, 0, 6, 13)), 32'd2);
    check("t1_hold_up",       32'(r_up[13][0]), 32'd1);
    check("t1_timeout_at",    32'(r_to[14][0]), 32'd1);
    check("t1_timeout_once",  32'(cnt(1, 0, 0, 19)), 32'd1);
    check("t1_cool_off",      32'(cnt(0, 0, 14, 19)), 32'd0);
    check("t1_cool_busy",     32'(r_busy[16][0]), 32'd1);
    check("t1_idle_after",    32'(r_busy[17][0]), 32'd0);

    // 2: all three raised together, hold 2
    clear_stim(); st_raise[0] = 3'b111;
    run_window(22, 8'd2);
    check("t2_ch0_kick_start", 32'(first_en(0, 22)), 32'd2);
    check("t2_ch1_kick_start", 32'(first_en(1, 22)), 32'd6);
    check("t2_ch2_kick_start", 32'(first_en(2, 22)), 32'd10);
    check("t2_ch2_timeouts",   32'(cnt(1, 2, 0, 21)), 32'd1);
    check("t2_all_idle",       32'(r_busy[20]), 32'd0);

    // 3: drop during hold, raise during cool ignored
    clear_stim(); st_raise[0] = 3'b010; st_drop[7] = 3'b010; st_raise[9] = 3'b010;
    run_window(14, 8'd8);
    check("t3_drop_coil_off", 32'(r_en[8][1]), 32'd0);
    check("t3_drop_up_off",   32'(r_up[8][1]), 32'd0);
    check("t3_no_timeout",    32'(cnt(1, 1, 0, 13)), 32'd0);
    check("t3_cool_busy",     32'(cnt(2, 1, 8, 10)), 32'd3);
    check("t3_raise_ignored", 32'(cnt(2, 1, 11, 13)), 32'd0);

    // 4: raise+drop in idle; drop while pending
    clear_stim(); st_raise[0] = 3'b100; st_drop[0] = 3'b100; st_raise[2] = 3'b100; st_drop[3] = 3'b100;
    run_window(10, 8'd8);
    check("t4_both_stay_idle", 32'(r_busy[1][2]), 32'd0);
    check("t4_pend_seen",      32'(r_busy[3][2]), 32'd1);
    check("t4_drop_pend_idle", 32'(cnt(2, 2, 4, 9)), 32'd0);
    check("t4_never_driven",   32'(cnt(0, 2, 0, 9)), 32'd0);

    // 5: zero hold goes straight from kick to cool
    clear_stim(); st_raise[0] = 3'b001;
    run_window(12, 8'd0);
    check("t5_kick_only",   32'(cnt(0, 0, 0, 11)), 32'd4);
    check("t5_up_after",    32'(r_up[6][0]), 32'd0);
    check("t5_cool_busy",   32'(r_busy[8][0]), 32'd1);
    check("t5_idle",        32'(r_busy[9][0]), 32'd0);
    check("t5_no_timeout",  32'(cnt(1, 0, 0, 11)), 32'd0);

    // 6: reset mid-kick (ch1 pending), mid-hold, then a clean raise
    clear_stim();
    st_raise[0] = 3'b011; st_rst[3] = 1'b1;
    st_raise[10] = 3'b001; st_rst[18] = 1'b1;
    st_raise[21] = 3'b001;
    run_window(40, 8'd8);
    check("t6_kick_rst_en",    32'(r_en[4]), 32'd0);
    check("t6_kick_rst_busy",  32'(r_busy[4]), 32'd0);
    check("t6_pending_lost",   32'(cnt(2, 1, 4, 39)), 32'd0);
    check("t6_hold_rst_en",    32'(r_en[19]), 32'd0);
    check("t6_hold_rst_up",    32'(r_up[19]), 32'd0);
    check("t6_post_kick",      32'(cnt(0, 0, 20, 26)), 32'd4);
    check("t6_post_kick_at",   32'(r_en[23][0]), 32'd1);
    check("t6_post_hold_pwm",  32'(cnt(0, 0, 27, 34)), 32'd2);
    check("t6_post_timeout",   32'(r_to[35][0]), 32'd1);
    check("t6_post_idle",      32'(r_busy[38][0]), 32'd0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
